// File: rtl/sp_ram_bank_wrap.sv
// Banked single-port SRAM wrapper.
// Tiles NUM_BANKS 2 KB (32x512) SRAM macros into one RAM_SIZE-byte word memory
// with a req/gnt/rvalid handshake, per-bank chip select, byte enables, a write
// bypass and a post-reset zero-init sweep.
// Ports:
//   clk, rst_i               clock, synchronous active-high reset
//   vccd1/vssd1              macro supplies (USE_POWER_PINS only)
//   req_i/gnt_o              request / accept (transfer = req_i & gnt_o)
//   addr_i, we_i, be_i,      byte address, write flag, byte enables,
//   wdata_i, bypass_en_i     write data, write suppression
//   rvalid_o/rdata_o         in-order response pulse and read data (0 on writes)
//   init_done_o              high once the zero-init sweep has finished

// Behavioural stand-in for port 0 of sky130_sram_2kbyte_1rw1r_32x512_8.
module sp_ram_bank_wrap_macro (
  input  logic        clk0,
  input  logic        csb0,
  input  logic        web0,
  input  logic [3:0]  wmask0,
  input  logic [8:0]  addr0,
  input  logic [31:0] din0,
  output logic [31:0] dout0
);

  logic [31:0] mem_q [512];
  logic [31:0] dout_q;

  // Active-low select / write enable, byte-masked write, registered read.
  always_ff @(posedge clk0) begin
    if (!csb0) begin
      if (!web0) begin
        for (int i = 0; i < 4; i++) begin
          if (wmask0[i]) mem_q[addr0][8*i +: 8] <= din0[8*i +: 8];
        end
      end else begin
        dout_q <= mem_q[addr0];
      end
    end
  end

  assign dout0 = dout_q;

endmodule

module sp_ram_bank_wrap #(
  parameter int unsigned RAM_SIZE   = 32768,
  parameter int unsigned ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_BANKS  = RAM_SIZE / 2048,
  parameter bit          RDATA_REG  = 1'b0,
  parameter bit          INIT_ZERO  = 1'b1
) (
`ifdef USE_POWER_PINS
  inout  wire                     vccd1,
  inout  wire                     vssd1,
`endif
  input  logic                    clk,
  input  logic                    rst_i,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic                    bypass_en_i,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    init_done_o
);

  localparam int unsigned BE_W   = DATA_WIDTH / 8;
  localparam int unsigned WORD_W = 9;
  localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   cnt_q, cnt_d;

  logic                xfer;
  logic [BANK_W-1:0]   bank_sel;
  logic                csb0   [NUM_BANKS];
  logic                web0;
  logic [BE_W-1:0]     wmask0;
  logic [WORD_W-1:0]   addr0;
  logic [DATA_WIDTH-1:0] din0;
  logic [DATA_WIDTH-1:0] bank_dout [NUM_BANKS];

  logic                rvalid1_q;
  logic                we1_q;
  logic [BANK_W-1:0]   bank1_q;
  logic [DATA_WIDTH-1:0] rdata_c;

  logic                unused_addr;
  assign unused_addr = ^addr_i[1:0];

  assign gnt_o       = (state_q == ST_RUN);
  assign init_done_o = (state_q == ST_RUN);
  // Nothing is accepted in the reset cycle so no response survives it.
  assign xfer        = req_i & gnt_o & ~rst_i;
  // Shift keeps NUM_BANKS=1 (ADDR_WIDTH=11) legal: bank is then always 0.
  assign bank_sel    = BANK_W'(addr_i >> 11);

  // State register.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q <= INIT_ZERO ? ST_INIT : ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and macro port-0 drive.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    web0    = 1'b1;
    wmask0  = be_i;
    addr0   = addr_i[10:2];
    din0    = wdata_i;
    for (int b = 0; b < NUM_BANKS; b++) csb0[b] = 1'b1;

    case (state_q)
      ST_INIT: begin
        // Sweep writes zero to the same word of every bank at once.
        cnt_d  = cnt_q + WORD_W'(1);
        web0   = 1'b0;
        wmask0 = {BE_W{1'b1}};
        addr0  = cnt_q;
        din0   = '0;
        for (int b = 0; b < NUM_BANKS; b++) csb0[b] = 1'b0;
        if (cnt_q == {WORD_W{1'b1}}) state_d = ST_RUN;
      end
      default: begin
        web0 = ~(we_i & ~bypass_en_i);
        for (int b = 0; b < NUM_BANKS; b++) begin
          csb0[b] = ~(xfer && (bank_sel == BANK_W'(b)));
        end
      end
    endcase
  end

  // Macro array; port 1 is unused and tied off on the real macro.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
`ifdef SKY130_SRAM_MACRO
    sky130_sram_2kbyte_1rw1r_32x512_8 u_macro (
`ifdef USE_POWER_PINS
      .vccd1  (vccd1),
      .vssd1  (vssd1),
`endif
      .clk0   (clk),
      .csb0   (csb0[b]),
      .web0   (web0),
      .wmask0 (wmask0),
      .addr0  (addr0),
      .din0   (din0),
      .dout0  (bank_dout[b]),
      .clk1   (1'b0),
      .csb1   (1'b1),
      .addr1  (9'd0),
      .dout1  ()
    );
`else
    sp_ram_bank_wrap_macro u_macro (
      .clk0   (clk),
      .csb0   (csb0[b]),
      .web0   (web0),
      .wmask0 (wmask0),
      .addr0  (addr0),
      .din0   (din0),
      .dout0  (bank_dout[b])
    );
`endif
  end

  // Response pipeline: bank and write flag follow the macro read by one cycle.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      rvalid1_q <= 1'b0;
      we1_q     <= 1'b0;
      bank1_q   <= '0;
    end else begin
      rvalid1_q <= xfer;
      if (xfer) begin
        we1_q   <= we_i;
        bank1_q <= bank_sel;
      end
    end
  end

  // Macro dout is already a register; gating keeps rdata 0 when idle or on writes.
  assign rdata_c = (rvalid1_q && !we1_q) ? bank_dout[bank1_q] : '0;

  if (RDATA_REG) begin : g_rdata_reg
    logic                  rvalid2_q;
    logic [DATA_WIDTH-1:0] rdata2_q;
    always_ff @(posedge clk) begin
      if (rst_i) begin
        rvalid2_q <= 1'b0;
        rdata2_q  <= '0;
      end else begin
        rvalid2_q <= rvalid1_q;
        rdata2_q  <= rdata_c;
      end
    end
    assign rvalid_o = rvalid2_q;
    assign rdata_o  = rdata2_q;
  end else begin : g_rdata_direct
    assign rvalid_o = rvalid1_q;
    assign rdata_o  = rdata_c;
  end

endmodule

// File: tb/tb_sp_ram_bank_wrap.sv
// Directed bench for sp_ram_bank_wrap, 8 KB (4 banks), read latency 1, zero-init on.
module tb_sp_ram_bank_wrap;

  localparam int unsigned AW = 13;

  logic          clk;
  logic          rst_i;
  logic          req_i;
  logic          gnt_o;
  logic [AW-1:0] addr_i;
  logic          we_i;
  logic [3:0]    be_i;
  logic [31:0]   wdata_i;
  logic          bypass_en_i;
  logic          rvalid_o;
  logic [31:0]   rdata_o;
  logic          init_done_o;

  int n_checks = 0;
  int n_pass   = 0;
  int low_cnt;

  sp_ram_bank_wrap #(
    .RAM_SIZE  (8192),
    .RDATA_REG (1'b0),
    .INIT_ZERO (1'b1)
  ) dut (
    .clk         (clk),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .addr_i      (addr_i),
    .we_i        (we_i),
    .be_i        (be_i),
    .wdata_i     (wdata_i),
    .bypass_en_i (bypass_en_i),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .init_done_o (init_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles with gnt_o low, bounded so a stuck INIT still ends the run.
  task automatic wait_grant(output int low);
    low = 0;
    for (int i = 0; i < 600 && !gnt_o; i++) begin
      low++;
      tick();
    end
  endtask

  // One accepted transfer; checks the response in the following cycle.
  task automatic xfer(input string tag, input logic we, input logic [AW-1:0] a,
                      input logic [3:0] be, input logic [31:0] wd, input logic byp,
                      input logic [31:0] exp);
    req_i = 1'b1; we_i = we; addr_i = a; be_i = be; wdata_i = wd; bypass_en_i = byp;
    tick();
    req_i = 1'b0; we_i = 1'b0; bypass_en_i = 1'b0;
    check($sformatf("%s_rvalid", tag), 32'(rvalid_o), 32'd1);
    check($sformatf("%s_rdata", tag), rdata_o, exp);
  endtask

  initial begin
    rst_i = 1'b1; req_i = 1'b0; addr_i = '0; we_i = 1'b0;
    be_i = 4'h0; wdata_i = '0; bypass_en_i = 1'b0;
    tick();
    tick();
    check("rst_gnt", 32'(gnt_o), 32'd0);
    check("rst_rvalid", 32'(rvalid_o), 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_init_done", 32'(init_done_o), 32'd0);

    // 1: init sweep length, then a zeroed word in the last bank.
    rst_i = 1'b0;
    req_i = 1'b1; addr_i = 13'h0804;
    wait_grant(low_cnt);
    check("init_low_cycles", 32'(low_cnt), 32'd512);
    check("init_done", 32'(init_done_o), 32'd1);
    check("held_req_no_resp", 32'(rvalid_o), 32'd0);
    req_i = 1'b0;
    xfer("t1_rd_1ffc", 1'b0, 13'h1FFC, 4'h0, 32'h0, 1'b0, 32'h0);

    // 2: full write and read-back, other bank untouched.
    xfer("t2_wr_804", 1'b1, 13'h0804, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0);
    xfer("t2_rd_804", 1'b0, 13'h0804, 4'h0, 32'h0, 1'b0, 32'hDEADBEEF);
    xfer("t2_rd_004", 1'b0, 13'h0004, 4'h0, 32'h0, 1'b0, 32'h0);

    // 3: byte enables, plus a be=0 write that must not change memory.
    xfer("t3_wr_full", 1'b1, 13'h0010, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0);
    xfer("t3_wr_be5", 1'b1, 13'h0010, 4'b0101, 32'h11223344, 1'b0, 32'h0);
    xfer("t3_rd", 1'b0, 13'h0010, 4'h0, 32'h0, 1'b0, 32'hDE22BE44);
    xfer("t3_wr_be0", 1'b1, 13'h0010, 4'h0, 32'hFFFFFFFF, 1'b0, 32'h0);
    xfer("t3_rd_be0", 1'b0, 13'h0010, 4'h0, 32'h0, 1'b0, 32'hDE22BE44);

    // 4: bypassed write is responded but suppressed; rvalid is a one-cycle pulse.
    xfer("t4_wr_byp", 1'b1, 13'h0010, 4'hF, 32'hFFFFFFFF, 1'b1, 32'h0);
    tick();
    check("t4_pulse", 32'(rvalid_o), 32'd0);
    xfer("t4_rd", 1'b0, 13'h0010, 4'h0, 32'h0, 1'b0, 32'hDE22BE44);

    // 5: back-to-back W, R (same address), R (other bank).
    req_i = 1'b1; we_i = 1'b1; addr_i = 13'h0020; be_i = 4'hF; wdata_i = 32'hA5A5A5A5;
    tick();
    check("t5_w_rvalid", 32'(rvalid_o), 32'd1);
    check("t5_w_rdata", rdata_o, 32'h0);
    we_i = 1'b0; addr_i = 13'h0020;
    tick();
    check("t5_r1_rvalid", 32'(rvalid_o), 32'd1);
    check("t5_r1_rdata", rdata_o, 32'hA5A5A5A5);
    addr_i = 13'h1820;
    tick();
    check("t5_r2_rvalid", 32'(rvalid_o), 32'd1);
    check("t5_r2_rdata", rdata_o, 32'h0);
    req_i = 1'b0;
    tick();
    check("t5_idle", 32'(rvalid_o), 32'd0);

    // 6: reset at a pending read, then again at INIT cnt=200.
    req_i = 1'b1; we_i = 1'b0; addr_i = 13'h0804; rst_i = 1'b1;
    tick();
    req_i = 1'b0;
    check("t6_rst_rvalid", 32'(rvalid_o), 32'd0);
    check("t6_rst_gnt", 32'(gnt_o), 32'd0);
    rst_i = 1'b0;
    for (int i = 0; i < 200; i++) tick();
    check("t6_cnt200_gnt", 32'(gnt_o), 32'd0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    wait_grant(low_cnt);
    check("t6_reinit_low_cycles", 32'(low_cnt), 32'd512);
    xfer("t6_rd_804", 1'b0, 13'h0804, 4'h0, 32'h0, 1'b0, 32'h0);
    xfer("t6_rd_010", 1'b0, 13'h0010, 4'h0, 32'h0, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
